pipe_ctrl_unit: RTL and testbench

//  Pipelined successor to the single-cycle control decoder. Decodes the ID-stage opcode into a

---
 rtl/pipe_ctrl_unit_pkg.sv | 47 ++++
 rtl/pipe_ctrl_unit_if.sv | 39 +++
 rtl/pipe_ctrl_unit_ctrl_decode.sv | 72 +++++++
 rtl/pipe_ctrl_unit.sv | 137 +++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared definitions for the pipelined control unit: opcode constants,
// control-bundle layout and the hazard classes chosen each cycle.
package pipe_ctrl_unit_pkg;

    // RV32I major opcodes recognised by the decoder
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_J     = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // Control-bundle bit positions
    localparam int CB_W         = 7;
    localparam int CB_MEM_READ  = 0;
    localparam int CB_MEM_WRITE = 1;
    localparam int CB_REG_WRITE = 2;
    localparam int CB_MEM_2_REG = 3;
    localparam int CB_ALU_SRC   = 4;
    localparam int CB_BRANCH    = 5;
    localparam int CB_JUMP      = 6;

    // Field order mirrors the bit positions above (mem_read is bit 0)
    typedef struct packed {
        logic jump;
        logic branch;
        logic alu_src;
        logic mem_2_reg;
        logic reg_write;
        logic mem_write;
        logic mem_read;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CB_BUBBLE = '0;

    // What the pipeline does this cycle, highest priority last
    typedef enum logic [1:0] {
        HZ_ADVANCE,
        HZ_LOAD_USE,
        HZ_REDIRECT,
        HZ_FREEZE
    } hazard_e;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Handshake bundle between the datapath (master) and the control unit (slave).
interface pipe_ctrl_unit_if #(
    parameter int REG_AW = 5,
    parameter int OPC_W  = 7,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [OPC_W-1:0]  id_opcode;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              ex_redirect;
    logic              mem_busy;
    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              ex_alu_src;
    logic              ex_branch;
    logic              ex_jump;
    logic              mem_read;
    logic              mem_write;
    logic              wb_reg_write;
    logic              wb_mem_2_reg;
    logic [REG_AW-1:0] wb_rd;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_redirect, mem_busy,
        input  pc_write, ifid_write, ifid_flush, ex_alu_src, ex_branch, ex_jump,
               mem_read, mem_write, wb_reg_write, wb_mem_2_reg, wb_rd, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_redirect, mem_busy,
        output pc_write, ifid_write, ifid_flush, ex_alu_src, ex_branch, ex_jump,
               mem_read, mem_write, wb_reg_write, wb_mem_2_reg, wb_rd, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
// Combinational ID-stage decoder: opcode -> control bundle plus source-register usage.
module ctrl_decode
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int OPC_W = 7
)
(
    input  logic             id_valid,
    input  logic [OPC_W-1:0] opcode,
    output ctrl_bundle_t     cb,
    output logic             rs1_used,
    output logic             rs2_used
);
    logic [CB_W-1:0] cb_bits;

    // Opcode lookup; anything unrecognised or not valid stays an all-zero bubble
    always_comb begin
        cb_bits  = '0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        if (id_valid) begin
            case (opcode)
                OPC_W'(OP_R): begin
                    cb_bits[CB_REG_WRITE] = 1'b1;
                    rs1_used = 1'b1;
                    rs2_used = 1'b1;
                end
                OPC_W'(OP_I): begin
                    cb_bits[CB_REG_WRITE] = 1'b1;
                    cb_bits[CB_ALU_SRC]   = 1'b1;
                    rs1_used = 1'b1;
                end
                OPC_W'(OP_L): begin
                    cb_bits[CB_MEM_READ]  = 1'b1;
                    cb_bits[CB_REG_WRITE] = 1'b1;
                    cb_bits[CB_MEM_2_REG] = 1'b1;
                    cb_bits[CB_ALU_SRC]   = 1'b1;
                    rs1_used = 1'b1;
                end
                OPC_W'(OP_S): begin
                    cb_bits[CB_MEM_WRITE] = 1'b1;
                    cb_bits[CB_ALU_SRC]   = 1'b1;
                    rs1_used = 1'b1;
                    rs2_used = 1'b1;
                end
                OPC_W'(OP_B): begin
                    cb_bits[CB_BRANCH] = 1'b1;
                    rs1_used = 1'b1;
                    rs2_used = 1'b1;
                end
                OPC_W'(OP_J): begin
                    cb_bits[CB_JUMP]      = 1'b1;
                    cb_bits[CB_REG_WRITE] = 1'b1;
                end
                OPC_W'(OP_JALR): begin
                    cb_bits[CB_JUMP]      = 1'b1;
                    cb_bits[CB_REG_WRITE] = 1'b1;
                    cb_bits[CB_ALU_SRC]   = 1'b1;
                    rs1_used = 1'b1;
                end
                OPC_W'(OP_LUI), OPC_W'(OP_AUIPC): begin
                    cb_bits[CB_REG_WRITE] = 1'b1;
                    cb_bits[CB_ALU_SRC]   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cb = ctrl_bundle_t'(cb_bits);

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes in ID, carries control through ID/EX, EX/MEM
// and MEM/WB, and arbitrates freeze / redirect flush / load-use stall.
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int OPC_W    = 7,
    parameter int CNT_W    = 16,
    parameter bit ZERO_REG = 1'b1
)
(
    input  logic            clk,
    input  logic            r,
    pipe_ctrl_unit_if.slave bus
);
    ctrl_bundle_t      id_cb;
    logic              id_rs1_used;
    logic              id_rs2_used;
    ctrl_bundle_t      idex_cb_reg;
    logic [REG_AW-1:0] idex_rd_reg;
    logic              exmem_mem_read_reg;
    logic              exmem_mem_write_reg;
    logic              exmem_reg_write_reg;
    logic              exmem_mem_2_reg_reg;
    logic [REG_AW-1:0] exmem_rd_reg;
    logic              memwb_reg_write_reg;
    logic              memwb_mem_2_reg_reg;
    logic [REG_AW-1:0] memwb_rd_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic [CNT_W-1:0]  flush_cnt_reg;
    logic              rd_guard_ok;
    logic              load_use;
    hazard_e           hz;
    logic              pc_write_en;
    logic              ifid_write_en;
    logic              ifid_flush_en;

    ctrl_decode #(.OPC_W(OPC_W)) u_decode (
        .id_valid (bus.id_valid),
        .opcode   (bus.id_opcode),
        .cb       (id_cb),
        .rs1_used (id_rs1_used),
        .rs2_used (id_rs2_used)
    );

    // With ZERO_REG set, a load into x0 never produces a usable value, so no stall
    assign rd_guard_ok = !ZERO_REG || (idex_rd_reg != '0);
    assign load_use    = idex_cb_reg.mem_read && rd_guard_ok &&
                         ((id_rs1_used && (bus.id_rs1 == idex_rd_reg)) ||
                          (id_rs2_used && (bus.id_rs2 == idex_rd_reg)));

    // Hazard priority: freeze over redirect over load-use
    always_comb begin
        hz = HZ_ADVANCE;
        if (bus.mem_busy)
            hz = HZ_FREEZE;
        else if (bus.ex_redirect)
            hz = HZ_REDIRECT;
        else if (load_use)
            hz = HZ_LOAD_USE;
    end

    // Front-end enables for the selected hazard class
    always_comb begin
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        ifid_flush_en = 1'b0;
        case (hz)
            HZ_FREEZE, HZ_LOAD_USE: begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
            end
            HZ_REDIRECT: ifid_flush_en = 1'b1;
            default: ;
        endcase
    end

    assign bus.pc_write     = r & pc_write_en;
    assign bus.ifid_write   = r & ifid_write_en;
    assign bus.ifid_flush   = r & ifid_flush_en;
    assign bus.ex_alu_src   = idex_cb_reg.alu_src;
    assign bus.ex_branch    = idex_cb_reg.branch;
    assign bus.ex_jump      = idex_cb_reg.jump;
    assign bus.mem_read     = exmem_mem_read_reg;
    assign bus.mem_write    = exmem_mem_write_reg;
    assign bus.wb_reg_write = memwb_reg_write_reg;
    assign bus.wb_mem_2_reg = memwb_mem_2_reg_reg;
    assign bus.wb_rd        = memwb_rd_reg;
    assign bus.stall_cnt    = stall_cnt_reg;
    assign bus.flush_cnt    = flush_cnt_reg;

    // Stage control registers: freeze holds everything, stall/redirect inject a bubble into ID/EX
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            idex_cb_reg         <= CB_BUBBLE;
            idex_rd_reg         <= '0;
            exmem_mem_read_reg  <= 1'b0;
            exmem_mem_write_reg <= 1'b0;
            exmem_reg_write_reg <= 1'b0;
            exmem_mem_2_reg_reg <= 1'b0;
            exmem_rd_reg        <= '0;
            memwb_reg_write_reg <= 1'b0;
            memwb_mem_2_reg_reg <= 1'b0;
            memwb_rd_reg        <= '0;
        end else if (hz != HZ_FREEZE) begin
            if (hz == HZ_ADVANCE) begin
                idex_cb_reg <= id_cb;
                idex_rd_reg <= bus.id_valid ? bus.id_rd : '0;
            end else begin
                idex_cb_reg <= CB_BUBBLE;
                idex_rd_reg <= '0;
            end
            exmem_mem_read_reg  <= idex_cb_reg.mem_read;
            exmem_mem_write_reg <= idex_cb_reg.mem_write;
            exmem_reg_write_reg <= idex_cb_reg.reg_write;
            exmem_mem_2_reg_reg <= idex_cb_reg.mem_2_reg;
            exmem_rd_reg        <= idex_rd_reg;
            memwb_reg_write_reg <= exmem_reg_write_reg;
            memwb_mem_2_reg_reg <= exmem_mem_2_reg_reg;
            memwb_rd_reg        <= exmem_rd_reg;
        end
    end

    // Saturating stall and flush counters
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if ((hz == HZ_LOAD_USE) && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if ((hz == HZ_REDIRECT) && (flush_cnt_reg != '1))
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: two instances (ZERO_REG=1/CNT_W=16 and ZERO_REG=0/CNT_W=2)
// share one stimulus stream; a cycle model queues expected stage outputs at drive time
// and they are popped and compared after the clock edge.
module tb_pipe_ctrl_unit;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_J     = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    typedef struct packed { logic mr, mw, rw, m2r, alu, br, jmp; } tcb_t;
    typedef struct packed {
        tcb_t        idex;
        logic [4:0]  idex_rd;
        logic        em_mr, em_mw, em_rw, em_m2r;
        logic [4:0]  em_rd;
        logic        mw_rw, mw_m2r;
        logic [4:0]  mw_rd;
        logic [15:0] stall, flush;
    } mst_t;
    typedef struct packed {
        logic alu, br, jmp, mr, mw, rw, m2r;
        logic [4:0]  rd;
        logic [15:0] stall, flush;
    } obs_t;
    typedef struct { int dut; obs_t exp; } sb_t;

    logic       clk = 1'b0;
    logic       r = 1'b0;
    logic       in_valid = 1'b0;
    logic [6:0] in_opc = '0;
    logic [4:0] in_rs1 = '0;
    logic [4:0] in_rs2 = '0;
    logic [4:0] in_rd = '0;
    logic       in_redir = 1'b0;
    logic       in_busy = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_cyc = 0;
    mst_t       ms [2];
    sb_t        sb_q [$];

    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.REG_AW(5), .OPC_W(7), .CNT_W(16)) bus0 ();
    pipe_ctrl_unit_if #(.REG_AW(5), .OPC_W(7), .CNT_W(2))  bus1 ();

    assign bus0.id_valid = in_valid;    assign bus1.id_valid = in_valid;
    assign bus0.id_opcode = in_opc;     assign bus1.id_opcode = in_opc;
    assign bus0.id_rs1 = in_rs1;        assign bus1.id_rs1 = in_rs1;
    assign bus0.id_rs2 = in_rs2;        assign bus1.id_rs2 = in_rs2;
    assign bus0.id_rd = in_rd;          assign bus1.id_rd = in_rd;
    assign bus0.ex_redirect = in_redir; assign bus1.ex_redirect = in_redir;
    assign bus0.mem_busy = in_busy;     assign bus1.mem_busy = in_busy;

    pipe_ctrl_unit #(.REG_AW(5), .OPC_W(7), .CNT_W(16), .ZERO_REG(1'b1)) dut0 (
        .clk (clk),
        .r   (r),
        .bus (bus0)
    );

    pipe_ctrl_unit #(.REG_AW(5), .OPC_W(7), .CNT_W(2), .ZERO_REG(1'b0)) dut1 (
        .clk (clk),
        .r   (r),
        .bus (bus1)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, act, exp);
        end
    endtask

    // Decode table as {mr,mw,rw,m2r,alu,br,jmp}
    function automatic tcb_t ref_cb(input logic v, input logic [6:0] o);
        tcb_t c;
        c = '0;
        if (v) begin
            case (o)
                OP_R:     c = 7'b0010000;
                OP_I:     c = 7'b0010100;
                OP_L:     c = 7'b1011100;
                OP_S:     c = 7'b0100100;
                OP_B:     c = 7'b0000010;
                OP_J:     c = 7'b0010001;
                OP_JALR:  c = 7'b0010101;
                OP_LUI:   c = 7'b0010100;
                OP_AUIPC: c = 7'b0010100;
                default:  c = '0;
            endcase
        end
        return c;
    endfunction

    // Source usage as {rs1_used, rs2_used}
    function automatic logic [1:0] ref_uses(input logic v, input logic [6:0] o);
        if (!v) return 2'b00;
        case (o)
            OP_R, OP_S, OP_B:    return 2'b11;
            OP_I, OP_L, OP_JALR: return 2'b10;
            default:             return 2'b00;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc(input int d, input logic [15:0] x);
        logic [15:0] lim;
        lim = (d == 0) ? 16'hFFFF : 16'd3;
        return (x == lim) ? x : x + 16'd1;
    endfunction

    // One clock of the reference pipeline; en = {pc_write, ifid_write, ifid_flush}
    task automatic model_step(input int d, output logic [2:0] en);
        mst_t s, n;
        tcb_t c;
        logic [1:0] u;
        logic lu;
        s = ms[d];
        n = s;
        c = ref_cb(in_valid, in_opc);
        u = ref_uses(in_valid, in_opc);
        lu = s.idex.mr && ((d == 1) || (s.idex_rd != 5'd0)) &&
             ((u[1] && (in_rs1 == s.idex_rd)) || (u[0] && (in_rs2 == s.idex_rd)));
        if (in_busy) begin
            en = 3'b000;
        end else begin
            n.mw_rw = s.em_rw; n.mw_m2r = s.em_m2r; n.mw_rd = s.em_rd;
            n.em_mr = s.idex.mr; n.em_mw = s.idex.mw; n.em_rw = s.idex.rw;
            n.em_m2r = s.idex.m2r; n.em_rd = s.idex_rd;
            if (in_redir) begin
                en = 3'b111; n.idex = '0; n.idex_rd = '0; n.flush = sat_inc(d, s.flush);
            end else if (lu) begin
                en = 3'b000; n.idex = '0; n.idex_rd = '0; n.stall = sat_inc(d, s.stall);
            end else begin
                en = 3'b110; n.idex = c; n.idex_rd = in_valid ? in_rd : 5'd0;
            end
        end
        ms[d] = n;
    endtask

    function automatic obs_t exp_of(input mst_t s);
        return {s.idex.alu, s.idex.br, s.idex.jmp, s.em_mr, s.em_mw,
                s.mw_rw, s.mw_m2r, s.mw_rd, s.stall, s.flush};
    endfunction

    function automatic obs_t sample_regs(input int d);
        if (d == 0)
            return {bus0.ex_alu_src, bus0.ex_branch, bus0.ex_jump, bus0.mem_read, bus0.mem_write,
                    bus0.wb_reg_write, bus0.wb_mem_2_reg, bus0.wb_rd, bus0.stall_cnt, bus0.flush_cnt};
        return {bus1.ex_alu_src, bus1.ex_branch, bus1.ex_jump, bus1.mem_read, bus1.mem_write,
                bus1.wb_reg_write, bus1.wb_mem_2_reg, bus1.wb_rd,
                14'd0, bus1.stall_cnt, 14'd0, bus1.flush_cnt};
    endfunction

    function automatic logic [2:0] sample_en(input int d);
        if (d == 0) return {bus0.pc_write, bus0.ifid_write, bus0.ifid_flush};
        return {bus1.pc_write, bus1.ifid_write, bus1.ifid_flush};
    endfunction

    task automatic compare_obs(input int d, input obs_t a, input obs_t e);
        check_val($sformatf("d%0d ex_alu_src", d),   32'(a.alu),   32'(e.alu));
        check_val($sformatf("d%0d ex_branch", d),    32'(a.br),    32'(e.br));
        check_val($sformatf("d%0d ex_jump", d),      32'(a.jmp),   32'(e.jmp));
        check_val($sformatf("d%0d mem_read", d),     32'(a.mr),    32'(e.mr));
        check_val($sformatf("d%0d mem_write", d),    32'(a.mw),    32'(e.mw));
        check_val($sformatf("d%0d wb_reg_write", d), 32'(a.rw),    32'(e.rw));
        check_val($sformatf("d%0d wb_mem_2_reg", d), 32'(a.m2r),   32'(e.m2r));
        check_val($sformatf("d%0d wb_rd", d),        32'(a.rd),    32'(e.rd));
        check_val($sformatf("d%0d stall_cnt", d),    32'(a.stall), 32'(e.stall));
        check_val($sformatf("d%0d flush_cnt", d),    32'(a.flush), 32'(e.flush));
    endtask

    // One transaction: drive at the falling edge, check enables, queue stage expectations,
    // then compare the queued values just after the rising edge.
    task automatic cyc(input logic r_val, input logic v, input logic [6:0] o,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] dd,
                       input logic rdr, input logic bz);
        logic [2:0] en_exp;
        sb_t ent;
        r = r_val; in_valid = v; in_opc = o; in_rs1 = a; in_rs2 = b; in_rd = dd;
        in_redir = rdr; in_busy = bz;
        #1;
        for (int d = 0; d < 2; d++) begin
            if (!r_val) begin
                ms[d] = '0;
                en_exp = 3'b000;
            end else begin
                model_step(d, en_exp);
            end
            check_val($sformatf("d%0d pc_w/ifid_w/ifid_flush", d), 32'(sample_en(d)), 32'(en_exp));
            ent.dut = d;
            ent.exp = exp_of(ms[d]);
            sb_q.push_back(ent);
        end
        @(posedge clk);
        #1;
        while (sb_q.size() != 0) begin
            ent = sb_q.pop_front();
            compare_obs(ent.dut, sample_regs(ent.dut), ent.exp);
        end
        $display("cyc %0d r=%b v=%b op=%h rs1=%0d rs2=%0d rd=%0d redir=%b busy=%b | stall0=%0d stall1=%0d flush0=%0d",
                 n_cyc, r_val, v, o, a, b, dd, rdr, bz, bus0.stall_cnt, bus1.stall_cnt, bus0.flush_cnt);
        n_cyc++;
        @(negedge clk);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    function automatic logic [6:0] pick_op(input int k);
        case (k)
            0: return OP_R;    1: return OP_I;     2: return OP_L;   3: return OP_S;
            4: return OP_B;    5: return OP_J;     6: return OP_JALR; 7: return OP_LUI;
            8: return OP_AUIPC;
            default: return OP_BAD;
        endcase
    endfunction

    initial begin
        ms[0] = '0;
        ms[1] = '0;
        @(negedge clk);

        // Reset held for three cycles under random inputs
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'($urandom), pick_op($urandom_range(0, 9)), 5'($urandom), 5'($urandom),
                5'($urandom), 1'($urandom), 1'($urandom));
        check_val("rst stall_cnt d0", 32'(bus0.stall_cnt), 32'd0);
        check_val("rst pc_write d0", 32'(bus0.pc_write), 32'd0);
        // First edge after release advances normally
        cyc(1'b1, 1'b1, OP_I, 5'd1, 5'd0, 5'd3, 1'b0, 1'b0);
        nops(3);

        // Load-use: lw x5 ; add x6,x5,x1 (held one extra cycle by the stall)
        cyc(1'b1, 1'b1, OP_L, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
        check_val("lu pc_write d0", 32'(bus0.pc_write), 32'd1);
        cyc(1'b1, 1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
        nops(4);
        check_val("lu stall_cnt d0", 32'(bus0.stall_cnt), 32'd1);

        // x0 guard: lw x0 ; add x6,x0,x1 -- stalls only the ZERO_REG=0 instance
        cyc(1'b1, 1'b1, OP_L, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, OP_R, 5'd0, 5'd1, 5'd6, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, OP_R, 5'd0, 5'd1, 5'd6, 1'b0, 1'b0);
        nops(4);
        check_val("x0 stall_cnt d0", 32'(bus0.stall_cnt), 32'd1);
        check_val("x0 stall_cnt d1", 32'(bus1.stall_cnt), 32'd2);

        // Redirect coinciding with a load-use hazard
        cyc(1'b1, 1'b1, OP_L, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
        nops(4);
        check_val("redir flush_cnt d0", 32'(bus0.flush_cnt), 32'd1);
        check_val("redir stall_cnt d0", 32'(bus0.stall_cnt), 32'd1);
        check_val("redir stall_cnt d1", 32'(bus1.stall_cnt), 32'd2);

        // Freeze for four cycles during lw/sw/add traffic
        cyc(1'b1, 1'b1, OP_L, 5'd2, 5'd0, 5'd10, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, OP_S, 5'd3, 5'd4, 5'd0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, OP_S, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, OP_R, 5'd1, 5'd2, 5'd11, 1'b0, 1'b0);
        nops(4);

        // Five back-to-back load-use pairs: the 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, OP_L, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
            cyc(1'b1, 1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
            cyc(1'b1, 1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0);
        end
        nops(3);
        check_val("sat stall_cnt d1", 32'(bus1.stall_cnt), 32'd3);
        check_val("sat stall_cnt d0", 32'(bus0.stall_cnt), 32'd6);

        // Random traffic with occasional redirect, freeze and reset
        for (int i = 0; i < 300; i++)
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0), pick_op($urandom_range(0, 9)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
